// File: rtl/st2cl_postafu.sv
// Packs the AFU's 12-bit streaming samples into 512-bit cache lines {head, payload}
// and writes them to the post-AFU write FIFO. Optional macro ST2CL_ERR_CNT_EN adds err_cnt.
module st2cl_postafu #(
    parameter int CL            = 512,
    parameter int CL_HEAD       = 16,
    parameter int CL_PAYLOAD    = 496,
    parameter int ST            = 12,
    parameter int W_LEN_CL_HEAD = 10
) (
    input  logic          clk,
    input  logic          rst_sync,
    input  logic [ST-1:0] sink_data,
    input  logic          sink_valid,
    input  logic          sink_sop,
    input  logic          sink_eop,
    output logic          sink_ready,
    input  logic          ff_almost_full,
    output logic          ff_wrreq,
    output logic [CL-1:0] ff_data,
    output logic          ff_wr_finish
`ifdef ST2CL_ERR_CNT_EN
    ,
    output logic [15:0]   err_cnt
`endif
);

    localparam int ST_PER_CL = CL_PAYLOAD / ST;
    localparam int IDX_W     = $clog2(CL_PAYLOAD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [3:0]                done_cnt;
    logic [CL_PAYLOAD-1:0]     acc;
    logic [CL_PAYLOAD-1:0]     acc_packed;
    logic [W_LEN_CL_HEAD-1:0]  slot;
    logic [IDX_W-1:0]          slot_base;
    logic                      first_flag;
    logic                      first_cur;
    logic                      accept;
    logic                      pack_beat;
    logic                      trigger;
    logic [CL_HEAD-1:0]        head;

    assign sink_ready = !rst_sync && (state != S_DONE) && !ff_almost_full;
    assign accept     = sink_valid && sink_ready;

    // NOTE: every signal driven here gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        pack_beat = 1'b0;
        case (state)
            S_IDLE: begin
                // A beat without sop outside a frame is dropped entirely.
                if (accept && sink_sop) begin
                    pack_beat = 1'b1;
                    state_nxt = sink_eop ? S_DONE : S_PACK;
                end
            end
            S_PACK: begin
                if (accept) begin
                    pack_beat = 1'b1;
                    if (sink_eop) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (done_cnt == 4'd15) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign trigger   = pack_beat && ((slot == W_LEN_CL_HEAD'(ST_PER_CL - 1)) || sink_eop);
    assign slot_base = IDX_W'(slot * ST);
    assign first_cur = (state == S_IDLE) || first_flag;
    assign head      = {{(CL_HEAD - W_LEN_CL_HEAD - 2){1'b0}}, first_cur, sink_eop,
                        slot + W_LEN_CL_HEAD'(1)};

    // Slots above the current one are always zero, so writing one slot keeps the padding clean.
    always_comb begin
        acc_packed                  = acc;
        acc_packed[slot_base +: ST] = sink_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: the accumulator is reset too, so a frame cut by reset can never leak into the next CL.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            acc          <= '0;
            slot         <= '0;
            first_flag   <= 1'b0;
            done_cnt     <= '0;
            ff_wrreq     <= 1'b0;
            ff_data      <= '0;
            ff_wr_finish <= 1'b0;
        end else begin
            ff_wrreq     <= trigger;
            ff_wr_finish <= trigger && sink_eop;
            done_cnt     <= (state == S_DONE) ? done_cnt + 4'd1 : 4'd0;
            if (trigger) begin
                ff_data    <= {head, acc_packed};
                acc        <= '0;
                slot       <= '0;
                first_flag <= 1'b0;
            end else if (pack_beat) begin
                acc        <= acc_packed;
                slot       <= slot + W_LEN_CL_HEAD'(1);
                first_flag <= first_cur;
            end
        end
    end

`ifdef ST2CL_ERR_CNT_EN
    logic proto_err;

    assign proto_err = accept && (((state == S_IDLE) && !sink_sop) ||
                                  ((state == S_PACK) && sink_sop));

    always_ff @(posedge clk) begin
        if (rst_sync) begin
            err_cnt <= '0;
        end else if (proto_err && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_st2cl_postafu.sv
// Randomised bench for st2cl_postafu: a queue-based cache-line model predicts every
// FIFO write, sink_ready and (with ST2CL_ERR_CNT_EN) err_cnt, cycle by cycle.
module tb_st2cl_postafu;

    localparam int CL        = 512;
    localparam int ST        = 12;
    localparam int ST_PER_CL = 41;

    logic          clk = 1'b0;
    logic          rst_sync = 1'b1;
    logic [ST-1:0] sink_data = '0;
    logic          sink_valid = 1'b0;
    logic          sink_sop = 1'b0;
    logic          sink_eop = 1'b0;
    logic          sink_ready;
    logic          ff_almost_full = 1'b0;
    logic          ff_wrreq;
    logic [CL-1:0] ff_data;
    logic          ff_wr_finish;
`ifdef ST2CL_ERR_CNT_EN
    logic [15:0]   err_cnt;
`endif

    st2cl_postafu dut (
        .clk            (clk),
        .rst_sync       (rst_sync),
        .sink_data      (sink_data),
        .sink_valid     (sink_valid),
        .sink_sop       (sink_sop),
        .sink_eop       (sink_eop),
        .sink_ready     (sink_ready),
        .ff_almost_full (ff_almost_full),
        .ff_wrreq       (ff_wrreq),
        .ff_data        (ff_data),
        .ff_wr_finish   (ff_wr_finish)
`ifdef ST2CL_ERR_CNT_EN
        ,
        .err_cnt        (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [ST-1:0] cur[$];
    bit            in_frame = 0;
    bit            first_pending = 0;
    int            done_left = 0;
    int            model_err = 0;
    bit            exp_pending;
    bit            exp_fin;
    logic [CL-1:0] exp_cl;

    task automatic check(input string tag, input logic [CL-1:0] got, input logic [CL-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [CL-1:0] build_cl(input bit first, input bit last);
        logic [CL-1:0] cl = '0;
        for (int k = 0; k < cur.size(); k++) cl[k*ST +: ST] = cur[k];
        cl[505:496] = 10'(cur.size());
        cl[506]     = last;
        cl[507]     = first;
        return cl;
    endfunction

    function automatic void model_reset();
        cur.delete();
        in_frame      = 0;
        first_pending = 0;
        done_left     = 0;
        model_err     = 0;
    endfunction

    function automatic void model_beat(input logic [ST-1:0] d, input bit s, input bit e);
        if (!in_frame) begin
            if (!s) begin
                if (model_err < 65535) model_err++;
                return;
            end
            in_frame      = 1;
            first_pending = 1;
        end else if (s) begin
            if (model_err < 65535) model_err++;
        end
        cur.push_back(d);
        if (cur.size() == ST_PER_CL || e) begin
            exp_cl        = build_cl(first_pending, e);
            exp_pending   = 1;
            exp_fin       = e;
            first_pending = 0;
            cur.delete();
            if (e) begin
                in_frame  = 0;
                done_left = 16;
            end
        end
    endfunction

    // One clock cycle: drive at the falling edge, check ready, advance, check outputs.
    task automatic step(input logic v, input logic [ST-1:0] d, input logic s, input logic e,
                        input logic af, input logic rst, output logic acc);
        bit exp_ready;
        sink_valid     = v;
        sink_data      = d;
        sink_sop       = s;
        sink_eop       = e;
        ff_almost_full = af;
        rst_sync       = rst;
        #1;
        exp_ready = !rst && !af && (done_left == 0);
        check("sink_ready", CL'(sink_ready), CL'(exp_ready));
        acc         = v && exp_ready;
        exp_pending = 0;
        exp_fin     = 0;
        if (rst) begin
            model_reset();
        end else begin
            if (done_left > 0) done_left--;
            if (acc) model_beat(d, s, e);
        end
        @(posedge clk);
        @(negedge clk);
        check("ff_wrreq", CL'(ff_wrreq), CL'(exp_pending));
        check("ff_wr_finish", CL'(ff_wr_finish), CL'(exp_fin));
        if (exp_pending) check("ff_data", ff_data, exp_cl);
        if (rst) check("ff_data_reset", ff_data, '0);
`ifdef ST2CL_ERR_CNT_EN
        check("err_cnt", CL'(err_cnt), CL'(model_err));
`endif
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, a);
    endtask

    task automatic do_reset(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, a);
    endtask

    // Sends one frame; dmode 0 = data equals beat index, 1 = random data.
    task automatic frame(input int n, input int dmode, input int af_at, input int af_len,
                         input int mid_sop, input bit rnd_gap, input bit rnd_af, input bit no_eop);
        int af_left = 0;
        for (int i = 0; i < n; i++) begin
            logic a = 1'b0;
            int   tries = 0;
            if (i == af_at) af_left = af_len;
            while (!a) begin
                logic          v;
                logic          af;
                logic [ST-1:0] d;
                v  = !(rnd_gap && ($urandom_range(0, 3) == 0));
                af = (af_left > 0) || (rnd_af && ($urandom_range(0, 7) == 0));
                if (af_left > 0) af_left--;
                d  = (dmode == 1) ? ST'($urandom) : ST'(i);
                step(v, d, (i == 0) || (i == mid_sop), (i == n - 1) && !no_eop, af, 1'b0, a);
                tries++;
                if (!a && tries > 100) begin
                    check("accept_timeout", CL'(0), CL'(1));
                    return;
                end
            end
        end
    endtask

    initial begin
        logic a;
        @(negedge clk);
        do_reset(3);
        idle(2);

        // Full single-CL frame, then the 16-cycle ready gap.
        frame(41, 0, -1, 0, -1, 0, 0, 0);
        idle(20);

        // Three CLs: 41 + 41 + 18.
        frame(100, 0, -1, 0, -1, 0, 0, 0);
        idle(20);

        // One-beat frame.
        step(1'b1, 12'hABC, 1'b1, 1'b1, 1'b0, 1'b0, a);
        idle(20);

        // Almost-full back-pressure mid-frame.
        frame(100, 0, 30, 5, -1, 0, 0, 0);
        idle(20);

        // Reset mid-frame discards the partial CL.
        frame(21, 0, -1, 0, -1, 0, 0, 1);
        do_reset(1);
        idle(2);
        frame(41, 1, -1, 0, -1, 0, 0, 0);
        idle(20);

        // Stray beat outside a frame, then a frame with an extra sop inside.
        step(1'b1, 12'h5A5, 1'b0, 1'b0, 1'b0, 1'b0, a);
        frame(60, 1, -1, 0, 10, 0, 0, 0);
        idle(20);
`ifdef ST2CL_ERR_CNT_EN
        check("err_cnt_two", CL'(err_cnt), CL'(2));
`endif

        // Randomised frames with gaps, back-pressure and boundary lengths.
        for (int f = 0; f < 20; f++) begin
            int n;
            case (f % 4)
                0:       n = ST_PER_CL;
                1:       n = 2 * ST_PER_CL;
                default: n = $urandom_range(1, 130);
            endcase
            frame(n, 1, -1, 0, ($urandom_range(0, 4) == 0) ? $urandom_range(1, 40) : -1, 1, 1, 0);
            idle($urandom_range(16, 22));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/st2cl_postafu.md
Name: st2CL_postAFU

Overview:
- Packs the AFU's streaming (ST) output back into 512-bit cache lines (CLs) and writes them into the post-AFU write FIFO for transfer to host memory.
- Mirror stage of the pre-AFU CL-to-ST converter; emits the same CL head format so host software parses both directions identically.
- Sits between the AFU source interface and the write-side FIFO.

Parameters:
- CL, 512, cache-line width in bits.
- CL_HEAD, 16, head width, occupies CL[CL-1 : CL-CL_HEAD].
- CL_PAYLOAD, 496, payload width, occupies CL[CL_PAYLOAD-1 : 0].
- ST, 12, ST sample width.
- w_len_CLHead, 10, width of the length field in the head.
- ST_PER_CL, CL_PAYLOAD/ST (41), samples per full CL; must be ≥1 and < 2^w_len_CLHead.

Ports:
- clk  in  1  clock
- rst_sync  in  1  synchronous reset, active high
- sink_data  in  ST  AFU sample
- sink_valid  in  1  sample valid
- sink_sop  in  1  first sample of frame
- sink_eop  in  1  last sample of frame
- sink_ready  out  1  block accepts the sample this cycle
- ff_almost_full  in  1  write-FIFO almost full; threshold leaves ≥2 free entries
- ff_wrreq  out  1  FIFO write strobe
- ff_data  out  CL  CL written to FIFO
- ff_wr_finish  out  1  one-cycle pulse: last CL of frame written

Behaviour:
- Beat accepted iff sink_valid && sink_ready.
- Reset: every output 0; FSM to S_IDLE; accumulator, slot counter, and head flags cleared. Reset mid-frame discards the partial CL with no ff_wrreq.
- CL format:
  - head rel bits [w_len_CLHead-1:0] = number of valid samples in this CL (1..ST_PER_CL);
  - rel bit 10 (CL bit 506) = last CL of frame;
  - rel bit 11 (CL bit 507) = first CL of frame;
  - other head bits 0.
  - Payload sample k of the CL at bits [k*ST+ST-1 : k*ST], LSB-first. Unused payload bits and bits [CL_PAYLOAD-1 : ST_PER_CL*ST] are 0.
- FSM:
  - S_IDLE: sink_ready = !ff_almost_full.
    - Accepted beat with sop: packed in slot 0, first-flag set, go to S_PACK, or to S_DONE if eop is also set.
    - Accepted beat without sop: dropped, counts as protocol error.
  - S_PACK: sink_ready = !ff_almost_full. Each accepted beat goes into the next slot.
    - sop seen here: treated as data and counted as an error.
    - Accepted eop: go to S_DONE.
  - S_DONE: sink_ready = 0 for 16 cycles (counter 0..15), then S_IDLE.
- CL emission:
  - Trigger: the accepted beat fills slot ST_PER_CL-1 or carries eop.
  - The cycle after that beat: ff_wrreq = 1 and ff_data = {head, payload} (registered, latency 1).
  - The accumulator clears in the trigger cycle, so the next beat lands in slot 0 of the following CL with no bubble; back-to-back full CLs give consecutive ff_wrreq.
- eop landing exactly on slot ST_PER_CL-1 emits one CL (len = ST_PER_CL, last = 1). No empty trailing CL.
- ff_wr_finish is asserted in the same cycle as the ff_wrreq carrying last = 1.
- ff_almost_full only gates sink_ready. A CL already triggered is always written the next cycle regardless of ff_almost_full, hence the ≥2-entry margin.
- A frame of N samples produces ceil(N/ST_PER_CL) CLs. No frame-length limit.

Optional Feature:
- Macro ST2CL_ERR_CNT_EN.
- Defined: adds output err_cnt [15:0], reset 0.
  - Increments by 1 per accepted beat that is a protocol error: no-sop beat in S_IDLE, or sop beat in S_PACK.
  - Saturates at 0xFFFF.
- Undefined: port and logic are absent. Error beats are still dropped (S_IDLE) or packed as data (S_PACK) exactly as above.

Test Plan:
- 41-beat frame, data = beat index, ff_almost_full = 0 → one ff_wrreq 1 cycle after eop beat; len = 41, first = last = 1, slot k = k; ff_wr_finish in the same cycle; sink_ready low for 16 cycles, then high.
- 100-beat continuous frame → 3 CLs on cycles after beats 40, 81, and 99:
  - CL0 len 41, first = 1;
  - CL1 len 41, no flags;
  - CL2 len 18, last = 1, payload bits [495:216] = 0.
- Single beat with sop = eop = 1, data 0xABC → ff_data[11:0] = 0xABC, rest of payload 0, len = 1, first = last = 1.
- 100-beat frame with ff_almost_full high for 5 cycles starting at beat 30 → sink_ready low for those 5 cycles, then high again; CLs identical to the 100-beat case.
- rst_sync pulsed after beat 20 of a frame → no ff_wrreq, all outputs 0; a following 41-beat frame yields one CL starting at slot 0.
- With ST2CL_ERR_CNT_EN: beat without sop in S_IDLE, then a normal frame containing an extra mid-frame sop → err_cnt = 2; the stray beat is absent from the payload and the mid-sop beat is packed.
